// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access and writeback pipeline stage.
// Runs loads/stores on the dmem request/grant/response bus, formats load data,
// and registers the writeback bundle toward the register files.
// Optional define MEM_WB_TIMEOUT_EN: bounds the RESP wait to TIMEOUT_CYCLES and
// reports a bus error on expiry. Without it RESP waits indefinitely.
module mem_wb_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_store_data,
    input  logic [4:0]  mem_rd_addr,
    input  logic        mem_wb_sel,
    input  logic        mem_is_store,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic        mem_wb_fp_en,
    input  logic        mem_wb_int_en,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd_addr,
    output logic        wb_fp_en,
    output logic        wb_int_en,
    output logic        wb_misalign,
    output logic        wb_bus_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_e;

    state_e      state_q;

    // Access context captured when the request is launched
    logic [1:0]  addr_lo_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [4:0]  rd_q;
    logic        store_q;
    logic        fp_en_q;
    logic        int_en_q;
    logic [31:0] rdata_q;

    // Registered bus drive
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    // Writeback registers and their next-state values
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q,  wb_data_d;
    logic [4:0]  wb_rd_q,    wb_rd_d;
    logic        wb_fp_q,    wb_fp_d;
    logic        wb_int_q,   wb_int_d;
    logic        wb_mis_q,   wb_mis_d;

    logic        memop;
    logic        aligned;
    logic        start;
    logic        resp_err;
    logic [31:0] wdata_lane;
    logic [3:0]  wstrb_lane;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

`ifdef MEM_WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             wb_err_q;
`endif

    assign memop = mem_wb_sel | mem_is_store;
    assign start = (state_q == S_IDLE) && mem_valid && memop && aligned;

    // Natural-alignment check of the incoming effective address
    always_comb begin
        case (mem_size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = ~mem_alu_result[0];
            default: aligned = (mem_alu_result[1:0] == 2'b00);
        endcase
    end

    // Store lane replication and byte strobes for the incoming access
    always_comb begin
        case (mem_size)
            2'd0: begin
                wdata_lane = {4{mem_store_data[7:0]}};
                wstrb_lane = 4'b0001 << mem_alu_result[1:0];
            end
            2'd1: begin
                wdata_lane = {2{mem_store_data[15:0]}};
                wstrb_lane = mem_alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_lane = mem_store_data;
                wstrb_lane = 4'b1111;
            end
        endcase
    end

    // Load lane selection and sign/zero extension of the captured read word
    always_comb begin
        case (addr_lo_q)
            2'd0:    ld_byte = rdata_q[7:0];
            2'd1:    ld_byte = rdata_q[15:8];
            2'd2:    ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase
        ld_half = addr_lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (size_q)
            2'd0:    ld_data = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'd1:    ld_data = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = rdata_q;
        endcase
    end

    // Access FSM: launches the request, waits for grant/response, captures read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            addr_lo_q <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            rd_q      <= '0;
            store_q   <= 1'b0;
            fp_en_q   <= 1'b0;
            int_en_q  <= 1'b0;
            rdata_q   <= '0;
`ifdef MEM_WB_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        req_q     <= 1'b1;
                        we_q      <= mem_is_store;
                        addr_q    <= {mem_alu_result[31:2], 2'b00};
                        wdata_q   <= wdata_lane;
                        wstrb_q   <= wstrb_lane;
                        addr_lo_q <= mem_alu_result[1:0];
                        size_q    <= mem_size;
                        uns_q     <= mem_unsigned;
                        rd_q      <= mem_rd_addr;
                        store_q   <= mem_is_store;
                        fp_en_q   <= mem_wb_fp_en;
                        int_en_q  <= mem_wb_int_en;
                        state_q   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (dmem_gnt) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= store_q ? S_DONE : S_RESP;
`ifdef MEM_WB_TIMEOUT_EN
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
`endif
                    end
                end
                S_RESP: begin
                    if (dmem_rvalid) begin
                        rdata_q <= dmem_rdata;
                        state_q <= S_DONE;
                    end
`ifdef MEM_WB_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_WB_TIMEOUT_EN
    assign resp_err = err_q;
`else
    // No timeout path: a response can never error, so the limit has no effect.
    localparam bit TimeoutCfgd = (TIMEOUT_CYCLES > 0);
    assign resp_err = 1'b0 & TimeoutCfgd;
`endif

    // Next writeback bundle: memory completion, ALU pass-through or misalignment
    always_comb begin
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_fp_d    = 1'b0;
        wb_int_d   = 1'b0;
        wb_mis_d   = 1'b0;
        if (state_q == S_DONE) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            if (store_q || resp_err) begin
                wb_data_d = '0;
            end else begin
                wb_data_d = ld_data;
                wb_fp_d   = fp_en_q;
                wb_int_d  = int_en_q;
            end
        end else if ((state_q == S_IDLE) && mem_valid) begin
            if (!memop) begin
                wb_valid_d = 1'b1;
                wb_data_d  = mem_alu_result;
                wb_rd_d    = mem_rd_addr;
                wb_fp_d    = mem_wb_fp_en;
                wb_int_d   = mem_wb_int_en;
            end else if (!aligned) begin
                wb_valid_d = 1'b1;
                wb_mis_d   = 1'b1;
                wb_data_d  = mem_alu_result;
                wb_rd_d    = mem_rd_addr;
            end
        end
    end

    // Writeback register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_fp_q    <= 1'b0;
            wb_int_q   <= 1'b0;
            wb_mis_q   <= 1'b0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_fp_q    <= wb_fp_d;
            wb_int_q   <= wb_int_d;
            wb_mis_q   <= wb_mis_d;
        end
    end

`ifdef MEM_WB_TIMEOUT_EN
    // Bus-error flag accompanies the writeback pulse of a timed-out load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_err_q <= 1'b0;
        end else begin
            wb_err_q <= (state_q == S_DONE) && err_q;
        end
    end
    assign wb_bus_err = wb_err_q;
`else
    assign wb_bus_err = 1'b0;
`endif

    assign mem_stall   = start || (state_q == S_REQ) || (state_q == S_RESP);
    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign dmem_wstrb  = wstrb_q;
    assign wb_valid    = wb_valid_q;
    assign wb_data     = wb_data_q;
    assign wb_rd_addr  = wb_rd_q;
    assign wb_fp_en    = wb_fp_q;
    assign wb_int_en   = wb_int_q;
    assign wb_misalign = wb_mis_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: vector table of single instructions driven through the stage
// with a scripted memory responder; writeback results are matched against a
// scoreboard queue of expected bundles, including the cycle they must appear in.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_alu_result = '0;
    logic [31:0] mem_store_data = '0;
    logic [4:0]  mem_rd_addr = '0;
    logic        mem_wb_sel = 1'b0;
    logic        mem_is_store = 1'b0;
    logic [1:0]  mem_size = '0;
    logic        mem_unsigned = 1'b0;
    logic        mem_wb_fp_en = 1'b0;
    logic        mem_wb_int_en = 1'b0;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_fp_en;
    logic        wb_int_en;
    logic        wb_misalign;
    logic        wb_bus_err;

    always #5 clk = ~clk;

    mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_valid      (mem_valid),
        .mem_alu_result (mem_alu_result),
        .mem_store_data (mem_store_data),
        .mem_rd_addr    (mem_rd_addr),
        .mem_wb_sel     (mem_wb_sel),
        .mem_is_store   (mem_is_store),
        .mem_size       (mem_size),
        .mem_unsigned   (mem_unsigned),
        .mem_wb_fp_en   (mem_wb_fp_en),
        .mem_wb_int_en  (mem_wb_int_en),
        .mem_stall      (mem_stall),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_gnt       (dmem_gnt),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .wb_valid       (wb_valid),
        .wb_data        (wb_data),
        .wb_rd_addr     (wb_rd_addr),
        .wb_fp_en       (wb_fp_en),
        .wb_int_en      (wb_int_en),
        .wb_misalign    (wb_misalign),
        .wb_bus_err     (wb_bus_err)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        wb_sel;
        logic        is_store;
        logic [1:0]  size;
        logic        uns;
        logic        fp;
        logic        in;
        int unsigned gw;
        int unsigned rw;
        logic [31:0] rdata;
        int unsigned lat;
        logic [31:0] e_data;
        logic        chk_data;
        logic        chk_rd;
        logic        e_fp;
        logic        e_int;
        logic        e_mis;
        logic        e_err;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
    } vec_t;

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
        logic        chk_data;
        logic        chk_rd;
        logic [4:0]  rd;
        logic        fp;
        logic        in;
        logic        mis;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t alu_op(input logic [31:0] res, input logic [4:0] rd,
                                    input logic fp, input logic in);
        vec_t v = '{default: '0};
        v.alu = res; v.rd = rd; v.fp = fp; v.in = in; v.lat = 1;
        v.e_data = res; v.chk_data = 1'b1; v.chk_rd = 1'b1; v.e_fp = fp; v.e_int = in;
        return v;
    endfunction

    function automatic vec_t load_op(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                                     input logic [4:0] rd, input logic fp, input logic in,
                                     input int unsigned gw, input int unsigned rw,
                                     input logic [31:0] rdata, input logic [31:0] e_data,
                                     input int unsigned lat);
        vec_t v = '{default: '0};
        v.alu = addr; v.size = size; v.uns = uns; v.rd = rd; v.fp = fp; v.in = in;
        v.wb_sel = 1'b1; v.gw = gw; v.rw = rw; v.rdata = rdata; v.lat = lat;
        v.e_data = e_data; v.chk_data = 1'b1; v.chk_rd = 1'b1; v.e_fp = fp; v.e_int = in;
        v.e_addr = {addr[31:2], 2'b00};
        return v;
    endfunction

    function automatic vec_t store_op(input logic [31:0] addr, input logic [1:0] size,
                                      input logic [31:0] sdata, input int unsigned gw,
                                      input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
                                      input int unsigned lat);
        vec_t v = '{default: '0};
        v.alu = addr; v.size = size; v.sdata = sdata; v.is_store = 1'b1;
        v.fp = 1'b1; v.in = 1'b1; v.rd = 5'd2; v.gw = gw; v.lat = lat;
        v.e_addr = {addr[31:2], 2'b00}; v.e_wdata = e_wdata; v.e_wstrb = e_wstrb;
        return v;
    endfunction

    function automatic vec_t mis_op(input logic [31:0] addr, input logic [1:0] size,
                                    input logic is_store);
        vec_t v = '{default: '0};
        v.alu = addr; v.size = size; v.is_store = is_store; v.wb_sel = ~is_store;
        v.fp = 1'b1; v.in = 1'b1; v.rd = 5'd1; v.lat = 1;
        v.e_data = addr; v.chk_data = 1'b1; v.e_mis = 1'b1;
        return v;
    endfunction

    // Writeback monitor: every wb_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && wb_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb: got wb_valid=1 with data 0x%08h, expected no writeback", wb_data);
            end else begin
                e = sb.pop_front();
                check32("wb_cycle", cyc, e.cyc);
                if (e.chk_data) check32("wb_data", wb_data, e.data);
                if (e.chk_rd) check32("wb_rd_addr", {27'b0, wb_rd_addr}, {27'b0, e.rd});
                check32("wb_fp_en", {31'b0, wb_fp_en}, {31'b0, e.fp});
                check32("wb_int_en", {31'b0, wb_int_en}, {31'b0, e.in});
                check32("wb_misalign", {31'b0, wb_misalign}, {31'b0, e.mis});
                check32("wb_bus_err", {31'b0, wb_bus_err}, {31'b0, e.err});
            end
        end
    end

    // Drive one instruction, emulate the memory, and queue its expected writeback
    task automatic run_op(input vec_t v, input string tag);
        int unsigned gcnt, rcnt, nstall;
        bit          granted, rdone, finished, stalled;
        exp_t        e;
        gcnt = 0; rcnt = 0; nstall = 0;
        granted = 1'b0; rdone = 1'b0; finished = 1'b0;
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_alu_result = v.alu; mem_store_data = v.sdata;
        mem_rd_addr = v.rd; mem_wb_sel = v.wb_sel; mem_is_store = v.is_store;
        mem_size = v.size; mem_unsigned = v.uns; mem_wb_fp_en = v.fp; mem_wb_int_en = v.in;
        dmem_rdata = v.rdata;
        e.cyc = cyc + v.lat; e.data = v.e_data; e.chk_data = v.chk_data; e.chk_rd = v.chk_rd;
        e.rd = v.rd; e.fp = v.e_fp; e.in = v.e_int; e.mis = v.e_mis; e.err = v.e_err;
        sb.push_back(e);
        for (int k = 0; k < 300; k++) begin
            if (k > 0) begin
                // Upstream fields change while stalled; the captured access must not
                mem_alu_result = $urandom;
                mem_store_data = $urandom;
                mem_size = 2'($urandom);
                mem_unsigned = 1'($urandom);
                mem_rd_addr = 5'($urandom);
            end
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b0;
            if (dmem_req) begin
                check32({tag, "_addr"}, dmem_addr, v.e_addr);
                check32({tag, "_we"}, {31'b0, dmem_we}, {31'b0, v.is_store});
                if (v.is_store) begin
                    check32({tag, "_wdata"}, dmem_wdata, v.e_wdata);
                    check32({tag, "_wstrb"}, {28'b0, dmem_wstrb}, {28'b0, v.e_wstrb});
                end
                if (gcnt == v.gw) dmem_gnt = 1'b1;
                else gcnt++;
            end else if (granted && !v.is_store && !rdone) begin
                if (rcnt == v.rw) begin
                    dmem_rvalid = 1'b1;
                    rdone = 1'b1;
                end else begin
                    rcnt++;
                end
            end
            #1;
            stalled = mem_stall;
            if (stalled) nstall++;
            @(posedge clk);
            if (dmem_gnt) granted = 1'b1;
            #1;
            if (!stalled) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got stall still high after 300 cycles, expected release", tag);
        end
        check32({tag, "_stall_cycles"}, nstall, v.lat - 1);
        mem_valid = 1'b0;
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        vec_t v;
        // Single-instruction vector table
        vecs.push_back(alu_op(32'h1234_5678, 5'd5, 1'b0, 1'b1));
        vecs.push_back(alu_op(32'hDEAD_BEEF, 5'd31, 1'b1, 1'b0));
        vecs.push_back(load_op(32'h0000_0103, 2'd0, 1'b0, 5'd7, 1'b0, 1'b1, 0, 0, 32'h80FF_0000, 32'hFFFF_FF80, 4));
        vecs.push_back(load_op(32'h0000_0103, 2'd0, 1'b1, 5'd8, 1'b0, 1'b1, 0, 0, 32'h80FF_0000, 32'h0000_0080, 4));
        vecs.push_back(load_op(32'h0000_0202, 2'd1, 1'b0, 5'd9, 1'b0, 1'b1, 2, 1, 32'h8001_7FFF, 32'hFFFF_8001, 7));
        vecs.push_back(load_op(32'h0000_0200, 2'd1, 1'b1, 5'd10, 1'b1, 1'b0, 0, 0, 32'h8001_F00F, 32'h0000_F00F, 4));
        vecs.push_back(load_op(32'h0000_0100, 2'd2, 1'b0, 5'd11, 1'b0, 1'b1, 1, 3, 32'hCAFE_BABE, 32'hCAFE_BABE, 8));
        vecs.push_back(load_op(32'h0000_0001, 2'd0, 1'b0, 5'd12, 1'b0, 1'b1, 0, 0, 32'h1234_56F0, 32'h0000_0056, 4));
        vecs.push_back(load_op(32'h0000_000E, 2'd1, 1'b0, 5'd13, 1'b0, 1'b1, 0, 0, 32'h9ABC_1234, 32'hFFFF_9ABC, 4));
        vecs.push_back(load_op(32'h0000_03FC, 2'd0, 1'b0, 5'd14, 1'b0, 1'b1, 0, 2, 32'h0000_00FF, 32'hFFFF_FFFF, 6));
        vecs.push_back(store_op(32'h0000_0202, 2'd1, 32'h0000_ABCD, 3, 32'hABCD_ABCD, 4'b1100, 6));
        vecs.push_back(store_op(32'h0000_0001, 2'd0, 32'h1234_56A5, 0, 32'hA5A5_A5A5, 4'b0010, 3));
        vecs.push_back(store_op(32'h0000_0104, 2'd3, 32'h1122_3344, 1, 32'h1122_3344, 4'b1111, 4));
        vecs.push_back(mis_op(32'h0000_0006, 2'd2, 1'b0));
        vecs.push_back(mis_op(32'h0000_000B, 2'd1, 1'b1));
        vecs.push_back(mis_op(32'h0000_0201, 2'd1, 1'b0));

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check32("rst_ctrl", {25'b0, dmem_req, dmem_we, wb_valid, wb_fp_en, wb_int_en, wb_misalign, wb_bus_err}, 32'h0);
        check32("rst_wb_data", wb_data, 32'h0);
        check32("rst_wb_rd", {27'b0, wb_rd_addr}, 32'h0);
        check32("rst_dmem_addr", dmem_addr, 32'h0);
        check32("rst_dmem_wdata", dmem_wdata, 32'h0);
        check32("rst_dmem_wstrb", {28'b0, dmem_wstrb}, 32'h0);
        check32("rst_stall", {31'b0, mem_stall}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a request abandons it; stale responses are ignored
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_alu_result = 32'h0000_0040; mem_wb_sel = 1'b1;
        mem_is_store = 1'b0; mem_size = 2'd2; mem_wb_int_en = 1'b1; dmem_gnt = 1'b0;
        @(posedge clk); #1;
        check32("midrst_req_before", {31'b0, dmem_req}, 32'h1);
        #2 rst_n = 1'b0;
        mem_valid = 1'b0;
        #1;
        check32("midrst_req_dropped", {31'b0, dmem_req}, 32'h0);
        check32("midrst_stall", {31'b0, mem_stall}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dmem_rvalid = 1'b1;
            dmem_gnt = 1'b1;
            dmem_rdata = $urandom;
            @(negedge clk);
            check32("stale_wb_valid", {31'b0, wb_valid}, 32'h0);
            check32("stale_req", {31'b0, dmem_req}, 32'h0);
            @(posedge clk); #1;
        end
        dmem_rvalid = 1'b0;
        dmem_gnt = 1'b0;

`ifdef MEM_WB_TIMEOUT_EN
        // No response: four RESP cycles then a bus-error writeback
        v = load_op(32'h0000_0080, 2'd2, 1'b0, 5'd20, 1'b0, 1'b1, 0, 1000, 32'h5555_AAAA, 32'h0, 7);
        v.e_err = 1'b1; v.e_fp = 1'b0; v.e_int = 1'b0; v.chk_rd = 1'b0;
        run_op(v, "timeout");
        // Response arriving in the limit cycle completes normally
        v = load_op(32'h0000_0084, 2'd2, 1'b0, 5'd21, 1'b0, 1'b1, 0, 3, 32'h5555_AAAA, 32'h5555_AAAA, 7);
        run_op(v, "timeout_edge");
`else
        v = alu_op(32'h0BAD_F00D, 5'd3, 1'b1, 1'b1);
        run_op(v, "tail_alu");
`endif

        repeat (3) @(posedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_wb: got no writeback, expected one in cycle %0d", e.cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
